// File: rtl/tri_reorder_dispatch.sv
// tri_reorder_dispatch
//   Accepts triangle jobs, issues each one to a geometry engine and a shader
//   engine in parallel, collects their out-of-order returns into a DEPTH-entry
//   reorder buffer, and retires the results strictly in allocation order.
//
// Parameters
//   DEPTH        outstanding triangles (power of two, >= 2)
//   ID_WIDTH     triangle ID width
//   GEO_WIDTH    packed viewport x/y + z geometry result width
//   COLOR_WIDTH  shaded color width
//   TAG_WIDTH    slot tag width, fixed at $clog2(DEPTH)
//
// Ports
//   clk_in, rst_n_in                          clock, async active-low reset
//   valid_in/ready_out/tri_id_in              job input channel
//   geo_valid_out/geo_ready_in/geo_tag_out    geometry-engine issue channel
//   shd_valid_out/shd_ready_in/shd_tag_out/
//   shd_tri_id_out                            shader issue channel
//   geo_ret_*                                 geometry return (always accepted)
//   shd_ret_*                                 shader return (always accepted)
//   valid_out/ready_in/tri_id_out/geo_out/
//   color_out/culled_out                      in-order result channel
//   err_out                                   sticky protocol-error flag
//
// Configuration
//   TRI_REORDER_CULL_DROP_EN  when defined, culled results are freed
//                             internally instead of being emitted.

module tri_reorder_dispatch #(
    parameter  int unsigned DEPTH       = 4,
    parameter  int unsigned ID_WIDTH    = 11,
    parameter  int unsigned GEO_WIDTH   = 162,
    parameter  int unsigned COLOR_WIDTH = 16,
    localparam int unsigned TAG_WIDTH   = $clog2(DEPTH)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    // job input
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [ID_WIDTH-1:0]    tri_id_in,
    // geometry issue
    output logic                   geo_valid_out,
    input  logic                   geo_ready_in,
    output logic [TAG_WIDTH-1:0]   geo_tag_out,
    // shader issue
    output logic                   shd_valid_out,
    input  logic                   shd_ready_in,
    output logic [TAG_WIDTH-1:0]   shd_tag_out,
    output logic [ID_WIDTH-1:0]    shd_tri_id_out,
    // geometry return
    input  logic                   geo_ret_valid_in,
    input  logic [TAG_WIDTH-1:0]   geo_ret_tag_in,
    input  logic [GEO_WIDTH-1:0]   geo_ret_data_in,
    input  logic                   geo_ret_cull_in,
    // shader return
    input  logic                   shd_ret_valid_in,
    input  logic [TAG_WIDTH-1:0]   shd_ret_tag_in,
    input  logic [COLOR_WIDTH-1:0] shd_ret_color_in,
    input  logic                   shd_ret_cull_in,
    // in-order results
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [ID_WIDTH-1:0]    tri_id_out,
    output logic [GEO_WIDTH-1:0]   geo_out,
    output logic [COLOR_WIDTH-1:0] color_out,
    output logic                   culled_out,
    // status
    output logic                   err_out
);

    localparam int unsigned          CNT_WIDTH = TAG_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    // Pointers, occupancy and per-slot status bits
    logic [TAG_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TAG_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [DEPTH-1:0]       busy_q, busy_d;
    logic [DEPTH-1:0]       gdone_q, gdone_d;
    logic [DEPTH-1:0]       sdone_q, sdone_d;
    logic [DEPTH-1:0]       gcull_q, gcull_d;
    logic [DEPTH-1:0]       scull_q, scull_d;

    // Issue registers (shared tag/ID, independent valids)
    logic                   ready_q, ready_d;
    logic                   geo_vld_q, geo_vld_d;
    logic                   shd_vld_q, shd_vld_d;
    logic [TAG_WIDTH-1:0]   iss_tag_q, iss_tag_d;
    logic [ID_WIDTH-1:0]    iss_id_q, iss_id_d;

    // Result output register
    logic                   out_vld_q, out_vld_d;
    logic [ID_WIDTH-1:0]    out_id_q, out_id_d;
    logic [GEO_WIDTH-1:0]   out_geo_q, out_geo_d;
    logic [COLOR_WIDTH-1:0] out_color_q, out_color_d;
    logic                   out_cull_q, out_cull_d;
    logic                   err_q, err_d;

    // Slot payload storage (only read once a slot is DONE, so no reset)
    logic [ID_WIDTH-1:0]    id_mem    [DEPTH];
    logic [GEO_WIDTH-1:0]   geo_mem   [DEPTH];
    logic [COLOR_WIDTH-1:0] color_mem [DEPTH];

    logic                   alloc;
    logic                   geo_ok;
    logic                   shd_ok;
    logic                   out_hs;
    logic                   retire;
    logic                   drop;
    logic                   load;
    logic [TAG_WIDTH-1:0]   nxt_head;
    logic                   head_done;
    logic                   head_cull;

    // Next-state logic for all control and output registers
    always_comb begin : ctrl_comb
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        busy_d      = busy_q;
        gdone_d     = gdone_q;
        sdone_d     = sdone_q;
        gcull_d     = gcull_q;
        scull_d     = scull_q;
        geo_vld_d   = geo_vld_q;
        shd_vld_d   = shd_vld_q;
        iss_tag_d   = iss_tag_q;
        iss_id_d    = iss_id_q;
        out_vld_d   = out_vld_q;
        out_id_d    = out_id_q;
        out_geo_d   = out_geo_q;
        out_color_d = out_color_q;
        out_cull_d  = out_cull_q;

        alloc  = valid_in & ready_q;
        geo_ok = geo_ret_valid_in & busy_q[geo_ret_tag_in] & ~gdone_q[geo_ret_tag_in];
        shd_ok = shd_ret_valid_in & busy_q[shd_ret_tag_in] & ~sdone_q[shd_ret_tag_in];
        out_hs = out_vld_q & ready_in;

        // Look one slot ahead on a handshake so back-to-back results stream
        nxt_head  = out_hs ? rd_ptr_q + 1'b1 : rd_ptr_q;
        head_done = busy_q[nxt_head] & gdone_q[nxt_head] & sdone_q[nxt_head];
        head_cull = gcull_q[nxt_head] | scull_q[nxt_head];

`ifdef TRI_REORDER_CULL_DROP_EN
        // With the output idle nxt_head is rd_ptr, so a culled head is freed here
        drop = ~out_vld_q & head_done & head_cull;
        load = (~out_vld_q | out_hs) & head_done & ~head_cull;
`else
        drop = 1'b0;
        load = (~out_vld_q | out_hs) & head_done;
`endif
        retire = out_hs | drop;

        if (retire) begin
            busy_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 1'b1;
        end

        if (geo_vld_q & geo_ready_in) geo_vld_d = 1'b0;
        if (shd_vld_q & shd_ready_in) shd_vld_d = 1'b0;

        if (alloc) begin
            busy_d[wr_ptr_q]  = 1'b1;
            gdone_d[wr_ptr_q] = 1'b0;
            sdone_d[wr_ptr_q] = 1'b0;
            gcull_d[wr_ptr_q] = 1'b0;
            scull_d[wr_ptr_q] = 1'b0;
            wr_ptr_d          = wr_ptr_q + 1'b1;
            geo_vld_d         = 1'b1;
            shd_vld_d         = 1'b1;
            iss_tag_d         = wr_ptr_q;
            iss_id_d          = tri_id_in;
        end

        if (geo_ok) begin
            gdone_d[geo_ret_tag_in] = 1'b1;
            gcull_d[geo_ret_tag_in] = geo_ret_cull_in;
        end
        if (shd_ok) begin
            sdone_d[shd_ret_tag_in] = 1'b1;
            scull_d[shd_ret_tag_in] = shd_ret_cull_in;
        end

        err_d   = err_q | (geo_ret_valid_in & ~geo_ok) | (shd_ret_valid_in & ~shd_ok);
        count_d = count_q + CNT_WIDTH'(alloc) - CNT_WIDTH'(retire);
        // Registered admit: a retire at full only reopens the input next cycle
        ready_d = (count_d < DEPTH_CNT) & ~geo_vld_d & ~shd_vld_d;

        if (load) begin
            out_vld_d   = 1'b1;
            out_id_d    = id_mem[nxt_head];
            out_geo_d   = head_cull ? '0 : geo_mem[nxt_head];
            out_color_d = color_mem[nxt_head];
            out_cull_d  = head_cull;
        end else if (out_hs) begin
            out_vld_d   = 1'b0;
        end
    end

    // Control registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin : ctrl_regs
        if (!rst_n_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            gdone_q     <= '0;
            sdone_q     <= '0;
            gcull_q     <= '0;
            scull_q     <= '0;
            ready_q     <= 1'b1;
            geo_vld_q   <= 1'b0;
            shd_vld_q   <= 1'b0;
            iss_tag_q   <= '0;
            iss_id_q    <= '0;
            out_vld_q   <= 1'b0;
            out_id_q    <= '0;
            out_geo_q   <= '0;
            out_color_q <= '0;
            out_cull_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            gdone_q     <= gdone_d;
            sdone_q     <= sdone_d;
            gcull_q     <= gcull_d;
            scull_q     <= scull_d;
            ready_q     <= ready_d;
            geo_vld_q   <= geo_vld_d;
            shd_vld_q   <= shd_vld_d;
            iss_tag_q   <= iss_tag_d;
            iss_id_q    <= iss_id_d;
            out_vld_q   <= out_vld_d;
            out_id_q    <= out_id_d;
            out_geo_q   <= out_geo_d;
            out_color_q <= out_color_d;
            out_cull_q  <= out_cull_d;
            err_q       <= err_d;
        end
    end

    // Slot payload writes; illegal returns never touch storage
    always_ff @(posedge clk_in) begin : slot_data
        if (alloc)  id_mem[wr_ptr_q]          <= tri_id_in;
        if (geo_ok) geo_mem[geo_ret_tag_in]   <= geo_ret_data_in;
        if (shd_ok) color_mem[shd_ret_tag_in] <= shd_ret_color_in;
    end

    assign ready_out      = ready_q;
    assign geo_valid_out  = geo_vld_q;
    assign geo_tag_out    = iss_tag_q;
    assign shd_valid_out  = shd_vld_q;
    assign shd_tag_out    = iss_tag_q;
    assign shd_tri_id_out = iss_id_q;
    assign valid_out      = out_vld_q;
    assign tri_id_out     = out_id_q;
    assign geo_out        = out_geo_q;
    assign color_out      = out_color_q;
    assign culled_out     = out_cull_q;
    assign err_out        = err_q;

endmodule

// File: tb/tb_tri_reorder_dispatch.sv
// Directed bench for tri_reorder_dispatch at default parameters.
module tb_tri_reorder_dispatch;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         valid_in;
    logic         ready_out;
    logic [10:0]  tri_id_in;
    logic         geo_valid_out;
    logic         geo_ready_in;
    logic [1:0]   geo_tag_out;
    logic         shd_valid_out;
    logic         shd_ready_in;
    logic [1:0]   shd_tag_out;
    logic [10:0]  shd_tri_id_out;
    logic         geo_ret_valid_in;
    logic [1:0]   geo_ret_tag_in;
    logic [161:0] geo_ret_data_in;
    logic         geo_ret_cull_in;
    logic         shd_ret_valid_in;
    logic [1:0]   shd_ret_tag_in;
    logic [15:0]  shd_ret_color_in;
    logic         shd_ret_cull_in;
    logic         valid_out;
    logic         ready_in;
    logic [10:0]  tri_id_out;
    logic [161:0] geo_out;
    logic [15:0]  color_out;
    logic         culled_out;
    logic         err_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    tri_reorder_dispatch dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .tri_id_in        (tri_id_in),
        .geo_valid_out    (geo_valid_out),
        .geo_ready_in     (geo_ready_in),
        .geo_tag_out      (geo_tag_out),
        .shd_valid_out    (shd_valid_out),
        .shd_ready_in     (shd_ready_in),
        .shd_tag_out      (shd_tag_out),
        .shd_tri_id_out   (shd_tri_id_out),
        .geo_ret_valid_in (geo_ret_valid_in),
        .geo_ret_tag_in   (geo_ret_tag_in),
        .geo_ret_data_in  (geo_ret_data_in),
        .geo_ret_cull_in  (geo_ret_cull_in),
        .shd_ret_valid_in (shd_ret_valid_in),
        .shd_ret_tag_in   (shd_ret_tag_in),
        .shd_ret_color_in (shd_ret_color_in),
        .shd_ret_cull_in  (shd_ret_cull_in),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .tri_id_out       (tri_id_out),
        .geo_out          (geo_out),
        .color_out        (color_out),
        .culled_out       (culled_out),
        .err_out          (err_out)
    );

    function automatic logic [161:0] gdat(input int t);
        return {2'b10, 32'hA5A5_0000 + 32'(t), 64'h0123_4567_89AB_CDEF,
                64'hFEDC_BA98_7654_3210 ^ 64'(t)};
    endfunction

    function automatic logic [15:0] cdat(input int t);
        return 16'hC000 + 16'(t);
    endfunction

    task automatic chk(input string nm, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_job(input logic [10:0] id, input logic [1:0] tag, input string nm);
        int n = 0;
        while (ready_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_ready"}, 192'(ready_out), 192'(1));
        valid_in  = 1'b1;
        tri_id_in = id;
        tick();
        valid_in  = 1'b0;
        chk({nm, "_geo_valid"}, 192'(geo_valid_out), 192'(1));
        chk({nm, "_shd_valid"}, 192'(shd_valid_out), 192'(1));
        chk({nm, "_geo_tag"}, 192'(geo_tag_out), 192'(tag));
        chk({nm, "_shd_tag"}, 192'(shd_tag_out), 192'(tag));
        chk({nm, "_shd_id"}, 192'(shd_tri_id_out), 192'(id));
    endtask

    task automatic ret(input logic gv, input logic [1:0] gt, input logic [161:0] gd,
                       input logic gc, input logic sv, input logic [1:0] st,
                       input logic [15:0] sc, input logic scl);
        geo_ret_valid_in = gv;
        geo_ret_tag_in   = gt;
        geo_ret_data_in  = gd;
        geo_ret_cull_in  = gc;
        shd_ret_valid_in = sv;
        shd_ret_tag_in   = st;
        shd_ret_color_in = sc;
        shd_ret_cull_in  = scl;
        tick();
        geo_ret_valid_in = 1'b0;
        geo_ret_cull_in  = 1'b0;
        shd_ret_valid_in = 1'b0;
        shd_ret_cull_in  = 1'b0;
    endtask

    task automatic pop();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        #2;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in         = 1'b0;
        valid_in         = 1'b0;
        tri_id_in        = '0;
        geo_ready_in     = 1'b1;
        shd_ready_in     = 1'b1;
        ready_in         = 1'b0;
        geo_ret_valid_in = 1'b0;
        geo_ret_tag_in   = '0;
        geo_ret_data_in  = '0;
        geo_ret_cull_in  = 1'b0;
        shd_ret_valid_in = 1'b0;
        shd_ret_tag_in   = '0;
        shd_ret_color_in = '0;
        shd_ret_cull_in  = 1'b0;

        // Reset state
        #12;
        chk("rst_valid_out", 192'(valid_out), 192'(0));
        chk("rst_geo_valid", 192'(geo_valid_out), 192'(0));
        chk("rst_shd_valid", 192'(shd_valid_out), 192'(0));
        chk("rst_err", 192'(err_out), 192'(0));
        chk("rst_culled", 192'(culled_out), 192'(0));
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
        chk("rel_ready", 192'(ready_out), 192'(1));
        chk("rel_tri_id", 192'(tri_id_out), 192'(0));
        chk("rel_geo", 192'(geo_out), 192'(0));
        chk("rel_color", 192'(color_out), 192'(0));
        chk("rel_shd_id", 192'(shd_tri_id_out), 192'(0));

        // Single job, tri_id 5, returns three cycles later
        send_job(11'd5, 2'd0, "single");
        tick();
        chk("single_geo_drop", 192'(geo_valid_out), 192'(0));
        chk("single_shd_drop", 192'(shd_valid_out), 192'(0));
        tick();
        tick();
        ret(1'b1, 2'd0, gdat(0), 1'b0, 1'b1, 2'd0, cdat(0), 1'b0);
        chk("single_not_early", 192'(valid_out), 192'(0));
        tick();
        chk("single_valid", 192'(valid_out), 192'(1));
        chk("single_id", 192'(tri_id_out), 192'(11'd5));
        chk("single_geo", 192'(geo_out), 192'(gdat(0)));
        chk("single_color", 192'(color_out), 192'(cdat(0)));
        chk("single_culled", 192'(culled_out), 192'(0));
        pop();
        chk("single_once", 192'(valid_out), 192'(0));

        // Out-of-order completion and full condition
        do_reset();
        send_job(11'd10, 2'd0, "ooo10");
        send_job(11'd11, 2'd1, "ooo11");
        send_job(11'd12, 2'd2, "ooo12");
        send_job(11'd13, 2'd3, "ooo13");
        chk("full_on_accept", 192'(ready_out), 192'(0));
        tick();
        tick();
        chk("full_ready", 192'(ready_out), 192'(0));
        chk("full_geo_idle", 192'(geo_valid_out), 192'(0));
        ret(1'b1, 2'd3, gdat(3), 1'b0, 1'b1, 2'd1, cdat(1), 1'b0);
        chk("ooo_hold_a", 192'(valid_out), 192'(0));
        ret(1'b1, 2'd1, gdat(1), 1'b0, 1'b1, 2'd3, cdat(3), 1'b0);
        chk("ooo_hold_b", 192'(valid_out), 192'(0));
        ret(1'b1, 2'd0, gdat(0), 1'b0, 1'b1, 2'd0, cdat(0), 1'b0);
        chk("ooo_hold_c", 192'(valid_out), 192'(0));
        ready_in = 1'b1;
        ret(1'b1, 2'd2, gdat(2), 1'b0, 1'b1, 2'd2, cdat(2), 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ooo_valid_%0d", k), 192'(valid_out), 192'(1));
            chk($sformatf("ooo_id_%0d", k), 192'(tri_id_out), 192'(10 + k));
            chk($sformatf("ooo_geo_%0d", k), 192'(geo_out), 192'(gdat(k)));
            chk($sformatf("ooo_color_%0d", k), 192'(color_out), 192'(cdat(k)));
            if (k == 0) chk("full_before_retire", 192'(ready_out), 192'(0));
            if (k == 1) chk("ready_after_retire", 192'(ready_out), 192'(1));
            tick();
        end
        ready_in = 1'b0;
        chk("ooo_drained", 192'(valid_out), 192'(0));

        // Backpressure on a DONE head
        send_job(11'd20, 2'd0, "bp");
        tick();
        ret(1'b1, 2'd0, gdat(7), 1'b0, 1'b1, 2'd0, cdat(7), 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), 192'(valid_out), 192'(1));
            chk($sformatf("bp_id_%0d", k), 192'(tri_id_out), 192'(11'd20));
            chk($sformatf("bp_geo_%0d", k), 192'(geo_out), 192'(gdat(7)));
            chk($sformatf("bp_color_%0d", k), 192'(color_out), 192'(cdat(7)));
            tick();
        end
        pop();
        chk("bp_done", 192'(valid_out), 192'(0));

        // Culled triangle, tri_id 7
        send_job(11'd7, 2'd1, "cull");
        tick();
        ret(1'b1, 2'd1, gdat(9), 1'b1, 1'b1, 2'd1, 16'h1234, 1'b0);
`ifdef TRI_REORDER_CULL_DROP_EN
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cull_dropped_%0d", k), 192'(valid_out), 192'(0));
            tick();
        end
`else
        tick();
        chk("cull_valid", 192'(valid_out), 192'(1));
        chk("cull_id", 192'(tri_id_out), 192'(11'd7));
        chk("cull_flag", 192'(culled_out), 192'(1));
        chk("cull_geo_zero", 192'(geo_out), 192'(0));
        chk("cull_color", 192'(color_out), 192'(16'h1234));
        pop();
`endif
        send_job(11'd8, 2'd2, "after_cull");
        tick();
        ret(1'b1, 2'd2, gdat(2), 1'b0, 1'b1, 2'd2, cdat(2), 1'b0);
        tick();
        chk("after_cull_valid", 192'(valid_out), 192'(1));
        chk("after_cull_id", 192'(tri_id_out), 192'(11'd8));
        chk("after_cull_flag", 192'(culled_out), 192'(0));
        pop();

        // Return to a free tag
        chk("err_clear", 192'(err_out), 192'(0));
        ret(1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd3, cdat(0), 1'b0);
        chk("err_free_tag", 192'(err_out), 192'(1));
        tick();
        chk("err_sticky", 192'(err_out), 192'(1));

        // Reset in the middle of activity
        send_job(11'd9, 2'd3, "mid");
        tick();
        ret(1'b1, 2'd3, gdat(3), 1'b0, 1'b1, 2'd3, cdat(3), 1'b0);
        tick();
        chk("mid_out_valid", 192'(valid_out), 192'(1));
        geo_ready_in = 1'b0;
        shd_ready_in = 1'b0;
        send_job(11'd15, 2'd0, "mid_pend");
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_valid_out", 192'(valid_out), 192'(0));
        chk("async_geo_valid", 192'(geo_valid_out), 192'(0));
        chk("async_shd_valid", 192'(shd_valid_out), 192'(0));
        chk("async_err", 192'(err_out), 192'(0));
        chk("async_ready", 192'(ready_out), 192'(1));
        @(negedge clk_in);
        rst_n_in     = 1'b1;
        geo_ready_in = 1'b1;
        shd_ready_in = 1'b1;
        tick();
        chk("post_rst_id", 192'(tri_id_out), 192'(0));
        chk("post_rst_geo", 192'(geo_out), 192'(0));
        chk("post_rst_color", 192'(color_out), 192'(0));
        ret(1'b1, 2'd3, gdat(3), 1'b0, 1'b0, 2'd0, '0, 1'b0);
        chk("late_return_err", 192'(err_out), 192'(1));
        tick();
        chk("late_return_no_out", 192'(valid_out), 192'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
